// File: rtl/vect_loader.sv
// Serial-to-parallel vector assembler: packs up to `N_MAX WIDTH-bit elements
// from a valid/ready stream into one vector held under a valid/ready handshake.
`ifndef N_MAX
`define N_MAX 4
`endif

module vect_loader #(
  parameter int WIDTH = 43,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CNT_W-1:0]          len,
  input  logic                      el_valid,
  input  logic [WIDTH-1:0]          el_data,
  output logic                      el_ready,
  output logic                      vect_valid,
  input  logic                      vect_ready,
  output logic [`N_MAX*WIDTH-1:0]   vect_out,
  output logic                      busy,
  output logic                      len_err
);

  localparam int NM = `N_MAX;
  localparam logic [CNT_W-1:0] N_MAX_C = CNT_W'(NM);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] idx_nxt;
  logic [WIDTH-1:0] slot [NM];
  logic             len_ok;
  logic             load;
  logic             wr_en;
  logic             last;

  assign len_ok  = (len != '0) && (len <= N_MAX_C);
  assign load    = (state == IDLE) && start && len_ok;
  assign wr_en   = (state == FILL) && el_valid;
  assign idx_nxt = idx + CNT_W'(1);
  assign last    = (idx_nxt == len_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = FILL;
      FILL:    if (wr_en && last) state_nxt = HOLD;
      HOLD:    if (vect_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    el_ready   = (state == FILL);
    vect_valid = (state == HOLD);
    busy       = (state != IDLE);
  end

  // Slots are cleared on every legal start so unused upper slots read as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q   <= '0;
      idx     <= '0;
      len_err <= 1'b0;
      for (int i = 0; i < NM; i++) slot[i] <= '0;
    end else begin
      len_err <= (state == IDLE) && start && !len_ok;
      if (load) begin
        len_q <= len;
        idx   <= '0;
        for (int i = 0; i < NM; i++) slot[i] <= '0;
      end else if (wr_en) begin
        idx <= idx_nxt;
        for (int i = 0; i < NM; i++)
          if (idx == CNT_W'(i)) slot[i] <= el_data;
      end
    end
  end

  for (genvar g = 0; g < NM; g++) begin : g_pack
    assign vect_out[g*WIDTH +: WIDTH] = slot[g];
  end

endmodule

// File: tb/tb_vect_loader.sv
// Directed bench for vect_loader with `N_MAX=4, WIDTH=43, CNT_W=8.
`ifndef N_MAX
`define N_MAX 4
`endif

module tb_vect_loader;

  localparam int WIDTH = 43;
  localparam int CNT_W = 8;
  localparam int VW    = `N_MAX * WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             el_valid;
  logic [WIDTH-1:0] el_data;
  logic             el_ready;
  logic             vect_valid;
  logic             vect_ready;
  logic [VW-1:0]    vect_out;
  logic             busy;
  logic             len_err;

  int checks = 0;
  int errors = 0;

  vect_loader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .el_valid(el_valid), .el_data(el_data), .el_ready(el_ready),
    .vect_valid(vect_valid), .vect_ready(vect_ready), .vect_out(vect_out),
    .busy(busy), .len_err(len_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] pk(input logic [WIDTH-1:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  // ctrl = {el_ready, vect_valid, busy, len_err}
  task automatic chk_ctrl(input string tag, input logic [3:0] exp);
    chk(tag, VW'({el_ready, vect_valid, busy, len_err}), VW'(exp));
  endtask

  task automatic feed(input logic [WIDTH-1:0] d);
    el_valid = 1'b1;
    el_data  = d;
    tick();
    el_valid = 1'b0;
  endtask

  task automatic begin_vec(input logic [CNT_W-1:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [VW-1:0] held;
    rst = 1'b0; start = 1'b0; len = '0; el_valid = 1'b0; el_data = '0; vect_ready = 1'b0;
    #3;
    chk_ctrl("reset_ctrl", 4'b0000);
    chk("reset_vect", vect_out, '0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk_ctrl("idle_after_reset", 4'b0000);

    // Full-length vector, back-to-back elements
    begin_vec(8'd4);
    chk_ctrl("fill_entered", 4'b1010);
    feed(43'd1); feed(43'd2); feed(43'd3);
    chk("no_valid_before_last", VW'(vect_valid), VW'(1'b0));
    feed(43'd4);
    chk_ctrl("hold_after_last", 4'b0110);
    chk("vec_1234", vect_out, pk(43'd4, 43'd3, 43'd2, 43'd1));
    vect_ready = 1'b1;
    tick();
    vect_ready = 1'b0;
    chk_ctrl("idle_after_consume", 4'b0000);
    chk("retained_after_consume", vect_out, pk(43'd4, 43'd3, 43'd2, 43'd1));

    // Prior vector of 7s, then a short vector with el_valid gaps
    begin_vec(8'd4);
    feed(43'd7); feed(43'd7); feed(43'd7); feed(43'd7);
    chk("vec_7s", vect_out, pk(43'd7, 43'd7, 43'd7, 43'd7));
    vect_ready = 1'b1; tick(); vect_ready = 1'b0;
    begin_vec(8'd2);
    chk("cleared_on_start", vect_out, '0);
    feed(43'd9);
    tick();
    chk_ctrl("gap1_ready", 4'b1010);
    tick();
    chk_ctrl("gap2_ready", 4'b1010);
    feed(43'd10);
    chk_ctrl("short_hold", 4'b0110);
    chk("vec_short", vect_out, pk(43'd0, 43'd0, 43'd10, 43'd9));
    vect_ready = 1'b1; tick(); vect_ready = 1'b0;

    // Illegal lengths
    begin_vec(8'd0);
    chk_ctrl("len0_err", 4'b0001);
    tick();
    chk_ctrl("len0_err_drop", 4'b0000);
    begin_vec(8'd5);
    chk_ctrl("len5_err", 4'b0001);
    tick();
    chk_ctrl("len5_err_drop", 4'b0000);
    begin_vec(8'd255);
    chk_ctrl("len255_err", 4'b0001);
    tick();

    // HOLD under back-pressure with stray start/el_valid
    begin_vec(8'd4);
    feed(43'd11); feed(43'd12); feed(43'd13); feed(43'h7FF_FFFF_FFFF);
    held = pk(43'h7FF_FFFF_FFFF, 43'd13, 43'd12, 43'd11);
    chk("vec_hold", vect_out, held);
    for (int i = 0; i < 10; i++) begin
      start    = i[0];
      len      = 8'd1;
      el_valid = ~i[0];
      el_data  = 43'd99;
      tick();
      chk("hold_stable", vect_out, held);
      chk_ctrl("hold_ctrl", 4'b0110);
    end
    start = 1'b0; el_valid = 1'b0;
    vect_ready = 1'b1; tick(); vect_ready = 1'b0;
    chk_ctrl("hold_released", 4'b0000);

    // Asynchronous reset mid-FILL
    begin_vec(8'd4);
    feed(43'd21); feed(43'd22);
    chk_ctrl("mid_fill", 4'b1010);
    #2 rst = 1'b0;
    #1;
    chk_ctrl("async_reset_ctrl", 4'b0000);
    chk("async_reset_vect", vect_out, '0);
    tick();
    rst = 1'b1;
    tick();
    chk_ctrl("post_reset_idle", 4'b0000);

    // Fresh single-element vector after reset
    begin_vec(8'd1);
    feed(43'd5);
    chk_ctrl("len1_hold", 4'b0110);
    chk("vec_len1", vect_out, pk(43'd0, 43'd0, 43'd0, 43'd5));
    vect_ready = 1'b1; tick(); vect_ready = 1'b0;
    chk_ctrl("final_idle", 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
